ram_port_arbiter: RTL and testbench

- Shares one synchronous add-and-store RAM between two requesters, A and B.
- The RAM has a 1-cycle registered read, write data = din1+din2 and a 9-bit dout.
- Arbitration is round-robin (fixed priority optional).
- The block sequences each access as grant → issue → response, and also sequences a whole-memory clear via the RAM's synchronous reset.
- Sits between client logic and the RAM instance. Only this block drives the RAM pins.

---
 rtl/ram_port_arbiter_if.sv | 25 ++
 rtl/ram_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle for one client of the shared add-and-store RAM.
// The arbiter takes one instance per requester on its slave modport.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              gnt;
  logic              ack;
  logic [DATA_W:0]   rdata;

  modport master (
    output req, we, addr, opa, opb,
    input  gnt, ack, rdata
  );

  modport slave (
    input  req, we, addr, opa, opb,
    output gnt, ack, rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a synchronous add-and-store RAM.
// Sequences grant -> issue -> response per access, plus a full clear.
module ram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int FAIR   = 1
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave port_a,
  ram_port_arbiter_if.slave port_b,
  input  logic              clr_req,
  output logic              clr_done,
  output logic              busy,
  output logic              ram_rst,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din1,
  output logic [DATA_W-1:0] ram_din2,
  input  logic [DATA_W:0]   ram_dout
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP,
    CLR
  } state_t;

  state_t state;
  state_t state_nx;

  logic              gnt_a_q;
  logic              gnt_b_q;
  logic              ack_a_q;
  logic              ack_b_q;
  logic [DATA_W:0]   rdata_a_q;
  logic [DATA_W:0]   rdata_b_q;
  logic              owner_b;
  logic              op_we;
  logic              last_b;

  logic              gnt_a_d;
  logic              gnt_b_d;
  logic              ack_a_d;
  logic              ack_b_d;
  logic [DATA_W:0]   rdata_a_d;
  logic [DATA_W:0]   rdata_b_d;
  logic              owner_b_d;
  logic              op_we_d;
  logic              last_b_d;
  logic              clr_done_d;
  logic              busy_d;
  logic              ram_rst_d;
  logic              ram_we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din1_d;
  logic [DATA_W-1:0] din2_d;

  logic take_clr;
  logic take_req;
  logic sel_b;

  // clr_req is still high in the clr_done cycle; don't clear twice
  assign take_clr = clr_req && !clr_done;
  assign take_req = port_a.req || port_b.req;

  always_comb begin
    sel_b = 1'b0;
    if (FAIR != 0)
      sel_b = port_b.req && (!port_a.req || !last_b);
    else
      sel_b = port_b.req && !port_a.req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      owner_b   <= 1'b0;
      op_we     <= 1'b0;
      last_b    <= 1'b1;
      clr_done  <= 1'b0;
      busy      <= 1'b0;
      ram_rst   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din1  <= '0;
      ram_din2  <= '0;
    end else begin
      state     <= state_nx;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      owner_b   <= owner_b_d;
      op_we     <= op_we_d;
      last_b    <= last_b_d;
      clr_done  <= clr_done_d;
      busy      <= busy_d;
      ram_rst   <= ram_rst_d;
      ram_we    <= ram_we_d;
      ram_addr  <= addr_d;
      ram_din1  <= din1_d;
      ram_din2  <= din2_d;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        priority case (1'b1)
          take_clr: state_nx = CLR;
          take_req: state_nx = ISSUE;
          default:  state_nx = IDLE;
        endcase
      end
      ISSUE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      CLR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    clr_done_d = 1'b0;
    ram_rst_d  = 1'b0;
    ram_we_d   = 1'b0;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    owner_b_d  = owner_b;
    op_we_d    = op_we;
    last_b_d   = last_b;
    addr_d     = ram_addr;
    din1_d     = ram_din1;
    din2_d     = ram_din2;
    busy_d     = (state_nx != IDLE);
    unique case (state)
      IDLE: begin
        priority case (1'b1)
          take_clr: ram_rst_d = 1'b1;
          take_req: begin
            owner_b_d = sel_b;
            op_we_d   = sel_b ? port_b.we   : port_a.we;
            addr_d    = sel_b ? port_b.addr : port_a.addr;
            din1_d    = sel_b ? port_b.opa  : port_a.opa;
            din2_d    = sel_b ? port_b.opb  : port_a.opb;
            ram_we_d  = op_we_d;
            gnt_a_d   = !sel_b;
            gnt_b_d   = sel_b;
          end
          default: ;
        endcase
      end
      RESP: begin
        ack_a_d  = !owner_b;
        ack_b_d  = owner_b;
        last_b_d = owner_b;
        if (!op_we) begin
          if (owner_b)
            rdata_b_d = ram_dout;
          else
            rdata_a_d = ram_dout;
        end
      end
      CLR:     clr_done_d = 1'b1;
      default: ;
    endcase
  end

  assign port_a.gnt   = gnt_a_q;
  assign port_b.gnt   = gnt_b_q;
  assign port_a.ack   = ack_a_q;
  assign port_b.ack   = ack_b_q;
  assign port_a.rdata = rdata_a_q;
  assign port_b.rdata = rdata_b_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a round-robin and a fixed-priority instance,
// each driving its own behavioural add-and-store RAM.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req   [2][2];
  logic       we    [2][2];
  logic [7:0] addr  [2][2];
  logic [7:0] opa   [2][2];
  logic [7:0] opb   [2][2];
  logic       gnt   [2][2];
  logic       ack   [2][2];
  logic [8:0] rdata [2][2];
  logic       clr_req  [2];
  logic       clr_done [2];
  logic       busy     [2];
  logic       ram_rst  [2];
  logic       ram_we   [2];
  logic [7:0] ram_addr [2];
  logic [7:0] ram_din1 [2];
  logic [7:0] ram_din2 [2];
  logic [8:0] ram_dout [2];

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] mrd [2][2];
  int lastb [2];

  for (genvar d = 0; d < 2; d++) begin : g
    ram_port_arbiter_if ia ();
    ram_port_arbiter_if ib ();
    logic [8:0] mem [256];
    logic [8:0] dout;

    assign ia.req  = req[d][0];
    assign ia.we   = we[d][0];
    assign ia.addr = addr[d][0];
    assign ia.opa  = opa[d][0];
    assign ia.opb  = opb[d][0];
    assign ib.req  = req[d][1];
    assign ib.we   = we[d][1];
    assign ib.addr = addr[d][1];
    assign ib.opa  = opa[d][1];
    assign ib.opb  = opb[d][1];
    assign gnt[d][0]   = ia.gnt;
    assign gnt[d][1]   = ib.gnt;
    assign ack[d][0]   = ia.ack;
    assign ack[d][1]   = ib.ack;
    assign rdata[d][0] = ia.rdata;
    assign rdata[d][1] = ib.rdata;
    assign ram_dout[d] = dout;

    ram_port_arbiter #(
      .ADDR_W(8),
      .DATA_W(8),
      .FAIR  (d == 0 ? 1 : 0)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .port_a   (ia),
      .port_b   (ib),
      .clr_req  (clr_req[d]),
      .clr_done (clr_done[d]),
      .busy     (busy[d]),
      .ram_rst  (ram_rst[d]),
      .ram_we   (ram_we[d]),
      .ram_addr (ram_addr[d]),
      .ram_din1 (ram_din1[d]),
      .ram_din2 (ram_din2[d]),
      .ram_dout (ram_dout[d])
    );

    // behavioural RAM: registered read, write stores din1+din2
    always @(posedge clk) begin
      if (ram_rst[d]) begin
        for (int i = 0; i < 256; i++) mem[i] <= '0;
        dout <= '0;
      end else begin
        if (ram_we[d])
          mem[ram_addr[d]] <= {1'b0, ram_din1[d]} + {1'b0, ram_din2[d]};
        dout <= mem[ram_addr[d]];
      end
    end
  end

  typedef struct {
    int         s;
    logic       w;
    logic [7:0] a;
    logic [7:0] oa;
    logic [7:0] ob;
    logic [8:0] want;
  } vec_t;

  vec_t tv [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic access(int d, int s, logic w, logic [7:0] a,
                        logic [7:0] oa, logic [7:0] ob, logic [8:0] want);
    req[d][s]  = 1'b1;
    we[d][s]   = w;
    addr[d][s] = a;
    opa[d][s]  = oa;
    opb[d][s]  = ob;
    tick();
    chk("gnt_c1", gnt[d][s], 1);
    chk("gnt_other_c1", gnt[d][1-s], 0);
    chk("ram_we_c1", ram_we[d], w);
    chk("ram_addr_c1", ram_addr[d], a);
    req[d][s] = 1'b0;
    tick();
    chk("gnt_c2", gnt[d][s], 0);
    chk("ram_we_c2", ram_we[d], 0);
    chk("busy_c2", busy[d], 1);
    tick();
    if (!w) mrd[d][s] = want;
    lastb[d] = s;
    chk("ack_c3", ack[d][s], 1);
    chk("ack_other_c3", ack[d][1-s], 0);
    chk("rdata_own", rdata[d][s], mrd[d][s]);
    chk("rdata_other", rdata[d][1-s], mrd[d][1-s]);
    chk("busy_c3", busy[d], 0);
    tick();
    chk("ack_c4", ack[d][s], 0);
  endtask

  task automatic round(int d, logic [7:0] aa, logic [7:0] ab,
                       logic [8:0] ea, logic [8:0] eb);
    int f;
    int o;
    f = (lastb[d] == 1) ? 0 : 1;
    o = 1 - f;
    req[d][0] = 1'b1; we[d][0] = 1'b0; addr[d][0] = aa;
    req[d][1] = 1'b1; we[d][1] = 1'b0; addr[d][1] = ab;
    mrd[d][0] = ea;
    mrd[d][1] = eb;
    tick();
    chk("rr_gnt_first", gnt[d][f], 1);
    chk("rr_gnt_loser", gnt[d][o], 0);
    req[d][f] = 1'b0;
    tick();
    tick();
    chk("rr_ack_first", ack[d][f], 1);
    chk("rr_noack_loser", ack[d][o], 0);
    chk("rr_rdata_first", rdata[d][f], mrd[d][f]);
    tick();
    chk("rr_gnt_second", gnt[d][o], 1);
    req[d][o] = 1'b0;
    tick();
    tick();
    chk("rr_ack_second", ack[d][o], 1);
    chk("rr_rdata_second", rdata[d][o], mrd[d][o]);
    lastb[d] = o;
  endtask

  task automatic do_clear(int d);
    clr_req[d] = 1'b1;
    tick();
    chk("clr_rst_pulse", ram_rst[d], 1);
    chk("clr_busy", busy[d], 1);
    chk("clr_done_early", clr_done[d], 0);
    tick();
    chk("clr_rst_off", ram_rst[d], 0);
    chk("clr_done", clr_done[d], 1);
    clr_req[d] = 1'b0;
    tick();
    chk("clr_done_pulse", clr_done[d], 0);
    chk("clr_no_repeat", ram_rst[d], 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      clr_req[d] = 1'b0;
      lastb[d] = 1;
      for (int s = 0; s < 2; s++) begin
        req[d][s] = 1'b0; we[d][s] = 1'b0; addr[d][s] = '0;
        opa[d][s] = '0;   opb[d][s] = '0;  mrd[d][s] = '0;
      end
    end

    tv[0] = '{0, 1'b1, 8'h10, 8'hFF, 8'h01, 9'h000};
    tv[1] = '{0, 1'b0, 8'h10, 8'h00, 8'h00, 9'h100};
    tv[2] = '{1, 1'b1, 8'h20, 8'h80, 8'h80, 9'h000};
    tv[3] = '{1, 1'b0, 8'h20, 8'h00, 8'h00, 9'h100};
    tv[4] = '{0, 1'b0, 8'h20, 8'h00, 8'h00, 9'h100};
    tv[5] = '{1, 1'b1, 8'h00, 8'h00, 8'h00, 9'h000};
    tv[6] = '{0, 1'b1, 8'hFF, 8'h12, 8'h34, 9'h000};
    tv[7] = '{1, 1'b0, 8'hFF, 8'h00, 8'h00, 9'h046};
    tv[8] = '{0, 1'b0, 8'h00, 8'h00, 8'h00, 9'h000};
    tv[9] = '{1, 1'b0, 8'h10, 8'h00, 8'h00, 9'h100};

    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", busy[d], 0);
      chk("rst_ram_rst", ram_rst[d], 0);
      chk("rst_ram_we", ram_we[d], 0);
      chk("rst_ram_addr", ram_addr[d], 0);
      chk("rst_clr_done", clr_done[d], 0);
      for (int s = 0; s < 2; s++) begin
        chk("rst_gnt", gnt[d][s], 0);
        chk("rst_ack", ack[d][s], 0);
        chk("rst_rdata", rdata[d][s], 0);
      end
    end
    rst = 1'b0;

    do_clear(0);
    do_clear(1);

    round(0, 8'h01, 8'h02, 9'h000, 9'h000);

    for (int i = 0; i < 10; i++)
      access(0, tv[i].s, tv[i].w, tv[i].a, tv[i].oa, tv[i].ob, tv[i].want);

    for (int k = 0; k < 2; k++)
      round(0, 8'h10, 8'hFF, 9'h100, 9'h046);

    // fixed priority: A holds req across three accesses, B starves
    req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 8'h01;
    req[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 8'h02;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fix_gnt_a", gnt[1][0], 1);
      chk("fix_gnt_b", gnt[1][1], 0);
      if (k == 2) req[1][0] = 1'b0;
      tick();
      tick();
      chk("fix_ack_a", ack[1][0], 1);
      chk("fix_noack_b", ack[1][1], 0);
    end
    tick();
    chk("fix_gnt_b_late", gnt[1][1], 1);
    req[1][1] = 1'b0;
    tick();
    tick();
    chk("fix_ack_b", ack[1][1], 1);
    chk("fix_rdata_b", rdata[1][1], 0);

    access(0, 1, 1'b1, 8'hFF, 8'h2A, 8'h2B, 9'h000);
    access(0, 1, 1'b0, 8'hFF, 8'h00, 8'h00, 9'h055);
    do_clear(0);
    access(0, 1, 1'b0, 8'hFF, 8'h00, 8'h00, 9'h000);
    access(0, 0, 1'b0, 8'h10, 8'h00, 8'h00, 9'h000);

    // clear and request together: clear goes first
    access(0, 0, 1'b1, 8'h10, 8'h07, 8'h08, 9'h000);
    clr_req[0] = 1'b1;
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 8'h10;
    tick();
    chk("cq_ram_rst", ram_rst[0], 1);
    chk("cq_no_gnt", gnt[0][0], 0);
    chk("cq_busy_clr", busy[0], 1);
    tick();
    chk("cq_clr_done", clr_done[0], 1);
    chk("cq_no_gnt2", gnt[0][0], 0);
    clr_req[0] = 1'b0;
    tick();
    chk("cq_gnt_a", gnt[0][0], 1);
    chk("cq_busy_issue", busy[0], 1);
    chk("cq_no_rst", ram_rst[0], 0);
    req[0][0] = 1'b0;
    tick();
    chk("cq_busy_resp", busy[0], 1);
    tick();
    chk("cq_ack_a", ack[0][0], 1);
    chk("cq_rdata_a", rdata[0][0], 0);
    mrd[0][0] = 9'h000;
    lastb[0] = 0;

    // reset during the RESP cycle of an A read
    access(0, 0, 1'b1, 8'h33, 8'h01, 8'h02, 9'h000);
    access(0, 0, 1'b0, 8'h33, 8'h00, 8'h00, 9'h003);
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 8'h33;
    tick();
    chk("mr_gnt", gnt[0][0], 1);
    req[0][0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_no_ack", ack[0][0], 0);
    chk("mr_rdata_a", rdata[0][0], 0);
    chk("mr_busy", busy[0], 0);
    chk("mr_ram_addr", ram_addr[0], 0);
    chk("mr_gnt_off", gnt[0][0], 0);
    for (int d = 0; d < 2; d++) begin
      lastb[d] = 1;
      mrd[d][0] = '0;
      mrd[d][1] = '0;
    end
    tick();
    chk("mr_no_late_ack", ack[0][0], 0);
    access(0, 1, 1'b0, 8'h33, 8'h00, 8'h00, 9'h003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
